// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared constants, sample type and index helper for the 16-point
//            FFT output path.
//            FFT_W    - width of one real/imaginary component
//            FFT_N    - frame length in points
//            FFT_LOGN - log2(FFT_N), width of bin indices
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

   localparam int FFT_W    = 8;
   localparam int FFT_N    = 16;
   localparam int FFT_LOGN = 4;

   typedef struct packed {
      logic [FFT_W-1:0] r;
      logic [FFT_W-1:0] im;
   } cplx_t;

   // Mirror the index bits: bit i of the result is bit LOGN-1-i of the input.
   function automatic logic [FFT_LOGN-1:0] bitrev(input logic [FFT_LOGN-1:0] a);
      logic [FFT_LOGN-1:0] res;
      for (int i = 0; i < FFT_LOGN; i++) begin
         res[i] = a[FFT_LOGN-1-i];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_pingpong_ram
// Purpose  : Two-bank frame store, 2 x N words of 2W bits. One synchronous
//            write port and one asynchronous (combinational) read port.
//            Contents are not reset.
// Ports    : clk        - clock, rising edge
//            we_i       - write enable
//            wr_bank_i  - bank written
//            wr_addr_i  - word address within bank
//            wr_data_i  - {real, imag}
//            rd_bank_i  - bank read
//            rd_addr_i  - word address within bank
//            rd_data_o  - {real, imag}, combinational from the array
// Revision : 1.0 - initial release
// ============================================================================
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int W    = FFT_W,
   parameter int N    = FFT_N,
   parameter int LOGN = FFT_LOGN
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              wr_bank_i,
   input  logic [LOGN-1:0]   wr_addr_i,
   input  logic [2*W-1:0]    wr_data_i,
   input  logic              rd_bank_i,
   input  logic [LOGN-1:0]   rd_addr_i,
   output logic [2*W-1:0]    rd_data_o
);

   logic [2*W-1:0] mem_q [0:1][0:N-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/fft16_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft16_bitrev_reorder
// Purpose  : Reorders the bit-reversed serial output of the 16-point FFT into
//            natural bin order, one sample per clock, using a ping-pong frame
//            store so consecutive frames stream without bubbles.
// Ports    : clk        - clock, rising edge
//            clear      - asynchronous active-high reset
//            in_valid / in_ready / in_sop / in_r / in_im - input stream
//            out_valid / out_ready / out_r / out_im      - output stream
//            out_index  - bin index of the presented sample
//            out_sop    - out_index == 0
//            out_eop    - out_index == N-1
//            err_resync - one-cycle pulse: in_sop seen mid-frame
// Revision : 1.0 - initial release
// ============================================================================
module fft16_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int W    = FFT_W,
   parameter int N    = FFT_N,
   parameter int LOGN = FFT_LOGN
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic [W-1:0]      in_r,
   input  logic [W-1:0]      in_im,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_r,
   output logic [W-1:0]      out_im,
   output logic [LOGN-1:0]   out_index,
   output logic              out_sop,
   output logic              out_eop,
   output logic              err_resync
);

   localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N-1);

   logic [LOGN-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic [1:0]      full_q, full_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_r_q, out_r_d;
   logic [W-1:0]    out_im_q, out_im_d;
   logic [LOGN-1:0] out_index_q, out_index_d;
   logic            out_sop_q, out_sop_d;
   logic            out_eop_q, out_eop_d;
   logic            err_q, err_d;

   logic            accept;
   logic            load;
   logic [LOGN-1:0] wr_eff_cnt;
   logic [LOGN-1:0] wr_addr;
   logic [2*W-1:0]  rd_data;

   assign in_ready = !full_q[wr_bank_q];
   assign accept   = in_valid && in_ready;
   assign load     = full_q[rd_bank_q] && (!out_valid_q || out_ready);

   // in_sop always restarts the frame at position 0; when wr_cnt is already 0
   // this is the normal case, otherwise the partial frame is abandoned.
   assign wr_eff_cnt = in_sop ? '0 : wr_cnt_q;
   assign wr_addr    = bitrev(wr_eff_cnt);

   fft_pingpong_ram #(
      .W    (W),
      .N    (N),
      .LOGN (LOGN)
   ) u_ram (
      .clk       (clk),
      .we_i      (accept),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (wr_addr),
      .wr_data_i ({in_r, in_im}),
      .rd_bank_i (rd_bank_q),
      .rd_addr_i (rd_cnt_q),
      .rd_data_o (rd_data)
   );

   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_cnt_d    = rd_cnt_q;
      rd_bank_d   = rd_bank_q;
      full_d      = full_q;
      out_valid_d = out_valid_q;
      out_r_d     = out_r_q;
      out_im_d    = out_im_q;
      out_index_d = out_index_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      err_d       = accept && in_sop && (wr_cnt_q != '0);

      // Write side
      if (accept) begin
         if (wr_eff_cnt == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
         end else begin
            wr_cnt_d = wr_eff_cnt + 1'b1;
         end
      end

      // Read side. Writes only target a non-full bank and reads only a full
      // one, so the two full_d updates never touch the same bit.
      if (load) begin
         {out_r_d, out_im_d} = rd_data;
         out_valid_d         = 1'b1;
         out_index_d         = rd_cnt_q;
         out_sop_d           = (rd_cnt_q == '0);
         out_eop_d           = (rd_cnt_q == LAST_IDX);
         if (rd_cnt_q == LAST_IDX) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         full_q      <= '0;
         out_valid_q <= 1'b0;
         out_r_q     <= '0;
         out_im_q    <= '0;
         out_index_q <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         out_valid_q <= out_valid_d;
         out_r_q     <= out_r_d;
         out_im_q    <= out_im_d;
         out_index_q <= out_index_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         err_q       <= err_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_r      = out_r_q;
   assign out_im     = out_im_q;
   assign out_index  = out_index_q;
   assign out_sop    = out_sop_q;
   assign out_eop    = out_eop_q;
   assign err_resync = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft16_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft16_bitrev_reorder
// Purpose  : Self-checking bench for fft16_bitrev_reorder. Accepted input
//            samples feed a frame-level reference model that pushes the
//            naturally ordered frame into a queue; an independent monitor
//            pops and compares every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft16_bitrev_reorder;

   localparam int W = 8;
   localparam int N = 16;

   logic         clk;
   logic         clear;
   logic         in_valid;
   logic         in_sop;
   logic [W-1:0] in_r;
   logic [W-1:0] in_im;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_r;
   logic [W-1:0] out_im;
   logic [3:0]   out_index;
   logic         out_sop;
   logic         out_eop;
   logic         err_resync;

   fft16_bitrev_reorder dut (
      .clk        (clk),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_sop     (in_sop),
      .in_r       (in_r),
      .in_im      (in_im),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_r      (out_r),
      .out_im     (out_im),
      .out_index  (out_index),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .err_resync (err_resync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] r;
      logic [7:0] im;
      logic [3:0] idx;
   } exp_t;

   exp_t       exp_q[$];
   int         m_cnt   = 0;
   int         exp_err = 0;
   logic [7:0] m_r  [N];
   logic [7:0] m_im [N];

   function automatic int brev(input int x);
      return ((x % 2) * 8) + (((x / 2) % 2) * 4) + (((x / 4) % 2) * 2) + ((x / 8) % 2);
   endfunction

   task automatic model_accept(input logic [7:0] r, input logic [7:0] im, input logic sop);
      exp_t e;
      if (sop && m_cnt != 0) begin
         m_cnt = 0;
         exp_err++;
      end
      m_r[m_cnt]  = r;
      m_im[m_cnt] = im;
      m_cnt++;
      if (m_cnt == N) begin
         // Input position p carries bin brev(p); so bin k came from position brev(k).
         for (int k = 0; k < N; k++) begin
            e.r   = m_r[brev(k)];
            e.im  = m_im[brev(k)];
            e.idx = 4'(k);
            exp_q.push_back(e);
         end
         m_cnt = 0;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   int acc_cnt   = 0;
   int stall_cnt = 0;
   int rdy_mode  = 0;   // 0: ready high, 1: random, 2: ready low

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic send(input logic [7:0] r, input logic [7:0] im, input logic sop);
      logic acc;
      int   waits;
      acc   = 1'b0;
      waits = 0;
      in_valid = 1'b1;
      in_r     = r;
      in_im    = im;
      in_sop   = sop;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) begin
            stall_cnt++;
            waits++;
            if (waits > 300) begin
               n_cmp++;
               n_bad++;
               $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waits);
               break;
            end
         end
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      if (acc) begin
         acc_cnt++;
         model_accept(r, im, sop);
      end
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check(name, exp_q.size(), 0);
   endtask

   // ---------------- monitor ----------------
   int          cyc = 0;
   int          err_seen = 0;
   bit          mark_first = 1'b0;
   int          first_pop_cyc = 0;
   int          last_pop_cyc = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      logic        held_v;
      logic [20:0] held;
      logic        err_prev;
      exp_t        e;
      held_v   = 1'b0;
      held     = '0;
      err_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (clear) begin
            held_v   = 1'b0;
            err_prev = 1'b0;
         end else begin
            if (held_v) begin
               check("hold_stable", {11'b0, out_valid, out_r, out_im, out_index}, {11'b0, held});
            end
            if (err_resync) begin
               err_seen++;
               check("err_pulse_width", {31'b0, err_prev}, 32'd0);
            end
            err_prev = err_resync;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_out: index %0d r %0h im %0h with nothing expected",
                           out_index, out_r, out_im);
               end else begin
                  e = exp_q.pop_front();
                  check("out_sample",
                        {10'b0, out_r, out_im, out_index, out_sop, out_eop},
                        {10'b0, e.r, e.im, e.idx, (e.idx == 4'd0), (e.idx == 4'd15)});
               end
               if (mark_first) begin
                  first_pop_cyc = cyc;
                  mark_first    = 1'b0;
               end
               last_pop_cyc = cyc;
            end
            held_v = out_valid && !out_ready;
            held   = {out_valid, out_r, out_im, out_index};
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int s0;
      int a0;
      int es0;
      clear    = 1'b1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_r     = '0;
      in_im    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_out_r", {24'b0, out_r}, 0);
      check("rst_out_im", {24'b0, out_im}, 0);
      check("rst_out_index", {28'b0, out_index}, 0);
      check("rst_out_sop", {31'b0, out_sop}, 0);
      check("rst_out_eop", {31'b0, out_eop}, 0);
      check("rst_err", {31'b0, err_resync}, 0);
      check("rst_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1;
      clear = 1'b0;
      repeat (2) idle_cycle();

      // Single frame, with first-output latency check
      rdy_mode = 0;
      for (int j = 0; j < N; j++) begin
         send(8'(brev(j)), 8'hF0 | 8'(j), j == 0);
      end
      @(negedge clk);
      check("lat_not_early", {31'b0, out_valid}, 0);
      @(negedge clk);
      check("lat_valid", {31'b0, out_valid}, 1);
      check("lat_index0", {28'b0, out_index}, 0);
      check("lat_r0", {24'b0, out_r}, 0);
      wait_drain("drain_single");

      // Back-to-back streaming
      s0 = stall_cnt;
      mark_first = 1'b1;
      for (int j = 0; j < 4 * N; j++) begin
         send(8'($urandom), 8'($urandom), (j % N) == 0);
      end
      wait_drain("drain_b2b");
      check("b2b_in_stalls", stall_cnt - s0, 0);
      check("b2b_out_span", last_pop_cyc - first_pop_cyc, 4 * N - 1);

      // Backpressure: consumer stalls 40 cycles
      rdy_mode = 2;
      idle_cycle();
      a0 = acc_cnt;
      fork
         begin
            for (int j = 0; j < 3 * N; j++) begin
               send(8'($urandom), 8'($urandom), (j % N) == 0);
            end
         end
         begin
            repeat (40) @(posedge clk);
            #2;
            check("bp_accepted", acc_cnt - a0, 2 * N);
            check("bp_in_ready_low", {31'b0, in_ready}, 0);
            rdy_mode = 0;
         end
      join
      wait_drain("drain_bp");

      // Random handshakes, 20 frames
      rdy_mode = 1;
      for (int f = 0; f < 20; f++) begin
         for (int j = 0; j < N; j++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            send(8'($urandom), 8'($urandom), j == 0);
         end
      end
      wait_drain("drain_random");
      rdy_mode = 0;
      repeat (3) idle_cycle();

      // Resync: in_sop after 5 samples
      es0 = err_seen;
      for (int j = 0; j < 5; j++) begin
         send(8'hA0 | 8'(j), 8'h55, j == 0);
      end
      for (int j = 0; j < N; j++) begin
         send(8'($urandom), 8'($urandom), j == 0);
      end
      wait_drain("drain_resync");
      repeat (2) idle_cycle();
      check("resync_pulses", err_seen - es0, 1);

      // Reset in the middle of frame 2
      rdy_mode = 2;
      idle_cycle();
      for (int j = 0; j < N + 7; j++) begin
         send(8'($urandom), 8'($urandom), (j % N) == 0);
      end
      #2;
      clear = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 0);
      check("mid_rst_out_r", {24'b0, out_r}, 0);
      check("mid_rst_out_index", {28'b0, out_index}, 0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 1);
      exp_q.delete();
      m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      clear    = 1'b0;
      rdy_mode = 0;
      idle_cycle();
      for (int j = 0; j < N; j++) begin
         send(8'($urandom), 8'($urandom), j == 0);
      end
      wait_drain("drain_after_reset");

      repeat (4) idle_cycle();
      check("err_total", err_seen, exp_err);
      check("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
